// File: rtl/ceres_ram_arb.sv
// Two-port round-robin arbiter for the main RAM line port: one RAM strobe per
// transaction, fixed-latency down-counter, one-cycle response pulse with captured data.
module ceres_ram_arb #(
    parameter int LINE_W  = 128,
    parameter int ADDR_W  = 18,
    parameter int LATENCY = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  p0_valid_i,
    input  logic [ADDR_W-1:0]     p0_addr_i,
    input  logic [LINE_W/8-1:0]   p0_wstrb_i,
    input  logic [LINE_W-1:0]     p0_wdata_i,
    output logic                  p0_rsp_valid_o,
    output logic [LINE_W-1:0]     p0_rdata_o,
    input  logic                  p1_valid_i,
    input  logic [ADDR_W-1:0]     p1_addr_i,
    input  logic [LINE_W/8-1:0]   p1_wstrb_i,
    input  logic [LINE_W-1:0]     p1_wdata_i,
    output logic                  p1_rsp_valid_o,
    output logic [LINE_W-1:0]     p1_rdata_o,
    output logic [ADDR_W-1:0]     ram_addr_o,
    output logic [LINE_W-1:0]     ram_wdata_o,
    output logic [LINE_W/8-1:0]   ram_wstrb_o,
    output logic                  ram_rd_en_o,
    input  logic [LINE_W-1:0]     ram_rdata_i,
    output logic [1:0]            gnt_o,
    output logic                  busy_o,
    output logic [1:0]            dbg_state_o
);
    localparam int SW = LINE_W / 8;
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 3);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_last;
    logic [1:0]          r_gnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [SW-1:0]       r_wstrb;
    logic [LINE_W-1:0]   r_wdata;
    logic [7:0]          r_cnt;
    logic [LINE_W-1:0]   r_rdata;

    logic                w_any;
    logic                w_pick1;
    logic [ADDR_W-1:0]   w_addr;
    logic [SW-1:0]       w_wstrb;
    logic [LINE_W-1:0]   w_wdata;
    logic                w_access;
    logic                w_resp;
    logic                w_is_rd;
    logic [LINE_W-1:0]   w_cap;

    // Port 1 wins only when it is alone or port 0 owned the previous transaction.
    assign w_any   = p0_valid_i | p1_valid_i;
    assign w_pick1 = p1_valid_i & (~p0_valid_i | ~r_last);
    assign w_addr  = w_pick1 ? p1_addr_i  : p0_addr_i;
    assign w_wstrb = w_pick1 ? p1_wstrb_i : p0_wstrb_i;
    assign w_wdata = w_pick1 ? p1_wdata_i : p0_wdata_i;

    assign w_access = (r_state == S_ACCESS);
    assign w_resp   = (r_state == S_RESP);
    assign w_is_rd  = (r_wstrb == '0);
    assign w_cap    = w_is_rd ? ram_rdata_i : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_gnt   <= '0;
            r_addr  <= '0;
            r_wstrb <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_pick1 ? 2'b10 : 2'b01;
                        r_last  <= w_pick1;
                        r_addr  <= w_addr;
                        r_wstrb <= w_wstrb;
                        r_wdata <= w_wdata;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_cnt   <= CNT_LOAD;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // cnt still equals its load value only in the first WAIT cycle
                    if (r_cnt == CNT_LOAD) begin
                        r_rdata <= w_cap;
                    end
                    if (r_cnt == 8'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ram_addr_o  = w_access ? r_addr  : '0;
    assign ram_wdata_o = w_access ? r_wdata : '0;
    assign ram_wstrb_o = w_access ? r_wstrb : '0;
    assign ram_rd_en_o = w_access & w_is_rd;

    assign p0_rsp_valid_o = w_resp & r_gnt[0];
    assign p1_rsp_valid_o = w_resp & r_gnt[1];
    assign p0_rdata_o     = p0_rsp_valid_o ? r_rdata : '0;
    assign p1_rdata_o     = p1_rsp_valid_o ? r_rdata : '0;

    assign gnt_o       = (r_state != S_IDLE) ? r_gnt : 2'b00;
    assign busy_o      = (r_state != S_IDLE);
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_ceres_ram_arb.sv
// Bench for ceres_ram_arb: a LATENCY=16 instance checked by a transaction monitor
// against an expected queue, plus a LATENCY=3 instance for the minimum-latency case.
module tb_ceres_ram_arb;
    localparam int LW = 128;
    localparam int AW = 18;
    localparam int SW = 16;
    localparam int LAT_A = 16;

    typedef struct {
        logic          port;
        logic [AW-1:0] addr;
        logic [SW-1:0] wstrb;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
    } txn_t;

    typedef struct {
        logic          port;
        logic [AW-1:0] addr;
        logic [SW-1:0] wstrb;
        logic [LW-1:0] wdata;
        logic [LW-1:0] exp_rdata;
        logic [1:0]    exp_gnt;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- shared request inputs ----------------
    logic          p0_valid, p1_valid;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [SW-1:0] p0_wstrb, p1_wstrb;
    logic [LW-1:0] p0_wdata, p1_wdata;

    // ---------------- instance A (LATENCY=16) ----------------
    logic          a_p0_rsp, a_p1_rsp;
    logic [LW-1:0] a_p0_rdata, a_p1_rdata;
    logic [AW-1:0] a_ram_addr;
    logic [LW-1:0] a_ram_wdata, a_ram_rdata;
    logic [SW-1:0] a_ram_wstrb;
    logic          a_ram_rd_en, a_busy;
    logic [1:0]    a_gnt, a_dbg;

    ceres_ram_arb #(.LINE_W(LW), .ADDR_W(AW), .LATENCY(LAT_A)) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .p0_valid_i(p0_valid), .p0_addr_i(p0_addr), .p0_wstrb_i(p0_wstrb), .p0_wdata_i(p0_wdata),
        .p0_rsp_valid_o(a_p0_rsp), .p0_rdata_o(a_p0_rdata),
        .p1_valid_i(p1_valid), .p1_addr_i(p1_addr), .p1_wstrb_i(p1_wstrb), .p1_wdata_i(p1_wdata),
        .p1_rsp_valid_o(a_p1_rsp), .p1_rdata_o(a_p1_rdata),
        .ram_addr_o(a_ram_addr), .ram_wdata_o(a_ram_wdata), .ram_wstrb_o(a_ram_wstrb),
        .ram_rd_en_o(a_ram_rd_en), .ram_rdata_i(a_ram_rdata),
        .gnt_o(a_gnt), .busy_o(a_busy), .dbg_state_o(a_dbg)
    );

    // ---------------- instance B (LATENCY=3) ----------------
    logic          b_p0_rsp, b_p1_rsp;
    logic [LW-1:0] b_p0_rdata, b_p1_rdata;
    logic [AW-1:0] b_ram_addr;
    logic [LW-1:0] b_ram_wdata, b_ram_rdata;
    logic [SW-1:0] b_ram_wstrb;
    logic          b_ram_rd_en, b_busy;
    logic [1:0]    b_gnt, b_dbg;

    ceres_ram_arb #(.LINE_W(LW), .ADDR_W(AW), .LATENCY(3)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .p0_valid_i(p0_valid), .p0_addr_i(p0_addr), .p0_wstrb_i(p0_wstrb), .p0_wdata_i(p0_wdata),
        .p0_rsp_valid_o(b_p0_rsp), .p0_rdata_o(b_p0_rdata),
        .p1_valid_i(p1_valid), .p1_addr_i(p1_addr), .p1_wstrb_i(p1_wstrb), .p1_wdata_i(p1_wdata),
        .p1_rsp_valid_o(b_p1_rsp), .p1_rdata_o(b_p1_rdata),
        .ram_addr_o(b_ram_addr), .ram_wdata_o(b_ram_wdata), .ram_wstrb_o(b_ram_wstrb),
        .ram_rd_en_o(b_ram_rd_en), .ram_rdata_i(b_ram_rdata),
        .gnt_o(b_gnt), .busy_o(b_busy), .dbg_state_o(b_dbg)
    );

    // RAM model: data for the strobed line appears the cycle after rd_en, junk otherwise
    function automatic logic [LW-1:0] pat(input logic [AW-1:0] a);
        logic [LW-1:0] v;
        if (a == 18'h00010) v = {16{8'hA5}};
        else                v = {4{14'h1A5, a}};
        return v;
    endfunction

    always @(posedge clk) begin
        a_ram_rdata <= a_ram_rd_en ? pat(a_ram_addr) : {$urandom, $urandom, $urandom, $urandom};
        b_ram_rdata <= b_ram_rd_en ? pat(b_ram_addr) : {$urandom, $urandom, $urandom, $urandom};
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    txn_t exp_q[$];
    logic [LW-1:0] exp3_q[$];

    task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- monitor for instance A ----------------
    logic mon_en = 1'b0;
    logic m_strobe;
    logic m_prev_busy = 1'b0;
    int   m_strobe_cyc = 0;
    int   n_strobe = 0;
    int   n_rsp = 0;
    txn_t m_t;

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            m_strobe = a_ram_rd_en || (a_ram_wstrb != '0);
            chk("rsp_exclusive", 128'(a_p0_rsp & a_p1_rsp), 128'(0));
            if (!a_p0_rsp) chk("p0_rdata_idle", a_p0_rdata, '0);
            if (!a_p1_rsp) chk("p1_rdata_idle", a_p1_rdata, '0);
            if (!m_strobe) begin
                chk("ram_addr_idle", 128'(a_ram_addr), '0);
                chk("ram_wdata_idle", a_ram_wdata, '0);
            end
            if (!a_busy) chk("gnt_idle", 128'(a_gnt), '0);
            if (a_busy && !m_prev_busy) chk("busy_rise_at_strobe", 128'(m_strobe), 128'(1));
            if (m_strobe) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_strobe: got strobe at cycle %0d expected none", cyc);
                end else begin
                    m_t = exp_q[0];
                    chk("strobe_addr", 128'(a_ram_addr), 128'(m_t.addr));
                    chk("strobe_wdata", a_ram_wdata, m_t.wdata);
                    chk("strobe_wstrb", 128'(a_ram_wstrb), 128'(m_t.wstrb));
                    chk("strobe_rd_en", 128'(a_ram_rd_en), 128'(m_t.wstrb == '0));
                    chk("strobe_gnt", 128'(a_gnt), m_t.port ? 128'(2) : 128'(1));
                    m_strobe_cyc = cyc;
                    n_strobe++;
                end
            end
            if (a_p0_rsp || a_p1_rsp) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_rsp: got response at cycle %0d expected none", cyc);
                end else begin
                    m_t = exp_q.pop_front();
                    chk("rsp_port", 128'(a_p1_rsp), 128'(m_t.port));
                    chk("rsp_rdata", m_t.port ? a_p1_rdata : a_p0_rdata, m_t.rdata);
                    chk("rsp_latency", 128'(cyc - m_strobe_cyc), 128'(LAT_A - 1));
                    chk("rsp_busy", 128'(a_busy), 128'(1));
                    n_rsp++;
                end
            end
            m_prev_busy = a_busy;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input logic port, input logic [AW-1:0] addr,
                           input logic [SW-1:0] wstrb, input logic [LW-1:0] wdata);
        if (port) begin
            p1_valid = 1'b1; p1_addr = addr; p1_wstrb = wstrb; p1_wdata = wdata;
        end else begin
            p0_valid = 1'b1; p0_addr = addr; p0_wstrb = wstrb; p0_wdata = wdata;
        end
    endtask

    task automatic push_exp(input logic port, input logic [AW-1:0] addr, input logic [SW-1:0] wstrb,
                            input logic [LW-1:0] wdata, input logic [LW-1:0] rdata);
        txn_t t;
        t.port = port; t.addr = addr; t.wstrb = wstrb; t.wdata = wdata; t.rdata = rdata;
        exp_q.push_back(t);
    endtask

    task automatic wait_rsp_a(input logic port, input logic drop, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (port ? a_p1_rsp : a_p0_rsp) begin
                at_cyc = cyc;
                if (drop) begin
                    if (port) p1_valid = 1'b0;
                    else      p0_valid = 1'b0;
                end
                return;
            end
        end
        n_cmp++; n_err++;
        $display("FAIL rsp_timeout: port %0d got no response expected one within 200 cycles", port);
    endtask

    task automatic wait_strobe_a(output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_ram_rd_en || a_ram_wstrb != '0) begin
                at_cyc = cyc;
                return;
            end
        end
        n_cmp++; n_err++;
        $display("FAIL strobe_timeout: got no RAM strobe expected one within 20 cycles");
    endtask

    task automatic run_vec(input vec_t v);
        int rc;
        push_exp(v.port, v.addr, v.wstrb, v.wdata, v.exp_rdata);
        set_req(v.port, v.addr, v.wstrb, v.wdata);
        wait_rsp_a(v.port, 1'b1, rc);
        if (rc >= 0) chk("vec_rsp_gnt", 128'(a_gnt), 128'(v.exp_gnt));
        @(negedge clk);
        chk("vec_busy_after_rsp", 128'(a_busy), '0);
        chk("vec_gnt_after_rsp", 128'(a_gnt), '0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    vec_t vecs[8];
    vec_t rv;
    int r1, r2, r3, r4, sc, s0, nr0, n_wait;
    int s3[$];
    int rsp3[$];

    initial begin
        vecs[0] = '{1'b0, 18'h00010, 16'h0000, 128'h0,            {16{8'hA5}},     2'b01};
        vecs[1] = '{1'b1, 18'h00022, 16'h000F, 128'h1122_3344,    128'h0,          2'b10};
        vecs[2] = '{1'b1, 18'h3FFFF, 16'h0000, {4{32'hDEAD_BEEF}}, pat(18'h3FFFF), 2'b10};
        vecs[3] = '{1'b0, 18'h3FFFF, 16'hFFFF, {128{1'b1}},        128'h0,          2'b01};
        vecs[4] = '{1'b0, 18'h00000, 16'h0000, 128'h0,            pat(18'h00000),  2'b01};
        vecs[5] = '{1'b1, 18'h155AA, 16'h0000, 128'h0,            pat(18'h155AA),  2'b10};
        vecs[6] = '{1'b0, 18'h00001, 16'h8000, {8'h77, 120'h0},   128'h0,          2'b01};
        vecs[7] = '{1'b1, 18'h2AAAA, 16'h0001, 128'h5A,           128'h0,          2'b10};

        rst_n = 1'b0;
        p0_valid = 1'b0; p0_addr = '0; p0_wstrb = '0; p0_wdata = '0;
        p1_valid = 1'b0; p1_addr = '0; p1_wstrb = '0; p1_wdata = '0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_busy", 128'(a_busy), '0);
        chk("rst_gnt", 128'(a_gnt), '0);
        chk("rst_state", 128'(a_dbg), '0);
        chk("rst_rd_en", 128'(a_ram_rd_en), '0);
        chk("rst_rsp", 128'({a_p0_rsp, a_p1_rsp}), '0);
        chk("rst_rdata", a_p0_rdata | a_p1_rdata, '0);

        // contention from reset: both held -> p0, p1, p0, p1
        push_exp(1'b0, 18'h00010, 16'h0000, 128'h0, {16{8'hA5}});
        push_exp(1'b1, 18'h00022, 16'h00F0, 128'hCAFE_0000, 128'h0);
        push_exp(1'b0, 18'h00010, 16'h0000, 128'h0, {16{8'hA5}});
        push_exp(1'b1, 18'h00022, 16'h00F0, 128'hCAFE_0000, 128'h0);
        set_req(1'b0, 18'h00010, 16'h0000, 128'h0);
        set_req(1'b1, 18'h00022, 16'h00F0, 128'hCAFE_0000);
        mon_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_rsp_a(1'b0, 1'b0, r1);
        wait_rsp_a(1'b1, 1'b0, r2);
        wait_rsp_a(1'b0, 1'b1, r3);
        wait_rsp_a(1'b1, 1'b1, r4);
        chk("contend_spacing_1", 128'(r2 - r1), 128'(LAT_A + 1));
        chk("contend_spacing_2", 128'(r3 - r2), 128'(LAT_A + 1));
        chk("contend_spacing_3", 128'(r4 - r3), 128'(LAT_A + 1));
        repeat (3) @(negedge clk);
        chk("contend_queue_empty", 128'(exp_q.size()), '0);

        // table-driven single transactions
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // random single transactions
        for (int i = 0; i < 6; i++) begin
            rv.port  = 1'($urandom_range(0, 1));
            rv.addr  = 18'($urandom_range(0, 18'h3FFFF));
            rv.wstrb = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(1, 16'hFFFF)) : 16'h0;
            rv.wdata = {$urandom, $urandom, $urandom, $urandom};
            rv.exp_rdata = (rv.wstrb == '0) ? pat(rv.addr) : '0;
            rv.exp_gnt = rv.port ? 2'b10 : 2'b01;
            run_vec(rv);
        end

        // request fields changing mid-transaction are ignored
        s0 = n_strobe;
        push_exp(1'b0, 18'h00020, 16'h0000, 128'h99, pat(18'h00020));
        set_req(1'b0, 18'h00020, 16'h0000, 128'h99);
        wait_strobe_a(sc);
        repeat (3) @(negedge clk);
        chk("midchg_in_wait", 128'(a_dbg), 128'(2));
        p0_addr = 18'h00033; p0_wdata = {4{32'h0BAD_F00D}}; p0_wstrb = 16'hFFFF;
        wait_rsp_a(1'b0, 1'b1, r1);
        repeat (3) @(negedge clk);
        chk("midchg_single_strobe", 128'(n_strobe - s0), 128'(1));

        // asynchronous reset while in WAIT drops the transaction
        push_exp(1'b0, 18'h00044, 16'h0000, 128'h0, pat(18'h00044));
        set_req(1'b0, 18'h00044, 16'h0000, 128'h0);
        wait_strobe_a(sc);
        repeat (4) @(negedge clk);
        chk("rstmid_in_wait", 128'(a_dbg), 128'(2));
        nr0 = n_rsp;
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy", 128'(a_busy), '0);
        chk("rstmid_gnt", 128'(a_gnt), '0);
        chk("rstmid_state", 128'(a_dbg), '0);
        chk("rstmid_rsp", 128'({a_p0_rsp, a_p1_rsp}), '0);
        exp_q.delete();
        p0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("rstmid_no_rsp", 128'(n_rsp - nr0), '0);
        push_exp(1'b1, 18'h00055, 16'h0000, 128'h0, pat(18'h00055));
        set_req(1'b1, 18'h00055, 16'h0000, 128'h0);
        wait_rsp_a(1'b1, 1'b1, r1);
        @(negedge clk);
        push_exp(1'b0, 18'h00066, 16'h0000, 128'h0, pat(18'h00066));
        push_exp(1'b1, 18'h00077, 16'h0003, 128'hABCD, 128'h0);
        set_req(1'b0, 18'h00066, 16'h0000, 128'h0);
        set_req(1'b1, 18'h00077, 16'h0003, 128'hABCD);
        wait_rsp_a(1'b0, 1'b1, r1);
        wait_rsp_a(1'b1, 1'b1, r2);
        chk("rstmid_contend_spacing", 128'(r2 - r1), 128'(LAT_A + 1));
        repeat (3) @(negedge clk);
        chk("final_queue_empty", 128'(exp_q.size()), '0);

        // minimum latency on instance B: back-to-back held p0 reads
        mon_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp3_q.push_back(pat(18'h00030));
        exp3_q.push_back(pat(18'h00030));
        n_wait = 0;
        set_req(1'b0, 18'h00030, 16'h0000, 128'h0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (b_ram_rd_en) s3.push_back(cyc);
            if (b_dbg == 2'd2) n_wait++;
            if (b_ram_wstrb != '0 || b_p1_rsp || b_p1_rdata != '0 || b_ram_wdata != '0) begin
                n_cmp++; n_err++;
                $display("FAIL lat3_stray: got write or p1 activity at cycle %0d expected none", cyc);
            end
            if (b_p0_rsp) begin
                rsp3.push_back(cyc);
                chk("lat3_rsp_gnt", 128'(b_gnt), 128'(1));
                chk("lat3_rsp_busy", 128'(b_busy), 128'(1));
                if (exp3_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL lat3_extra_rsp: got response at cycle %0d expected none", cyc);
                end else begin
                    chk("lat3_rdata", b_p0_rdata, exp3_q.pop_front());
                end
                if (rsp3.size() == 2) p0_valid = 1'b0;
            end
        end
        p0_valid = 1'b0;
        chk("lat3_strobe_count", 128'(s3.size()), 128'(2));
        chk("lat3_rsp_count", 128'(rsp3.size()), 128'(2));
        chk("lat3_wait_cycles", 128'(n_wait), 128'(2));
        if (s3.size() == 2 && rsp3.size() == 2) begin
            chk("lat3_accept_spacing", 128'(s3[1] - s3[0]), 128'(4));
            chk("lat3_first_latency", 128'(rsp3[0] - s3[0]), 128'(2));
            chk("lat3_rsp_spacing", 128'(rsp3[1] - rsp3[0]), 128'(4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
